// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR filter.
package fir_pkg;

   typedef enum logic [1:0] {CLEAR, IDLE, MAC, OUT} state_e;

   localparam int MaxAccWidth = 128;

   function automatic int acc_width(input int data_width, input int coeff_width, input int order);
      return data_width + coeff_width + ((order < 1) ? 1 : $clog2(order + 1));
   endfunction

   // Round half up, arithmetic shift right, then clamp to a data_width signed range.
   function automatic logic signed [MaxAccWidth-1:0] sat_round(
      input logic signed [MaxAccWidth-1:0] value,
      input int shift,
      input int data_width
   );
      logic signed [MaxAccWidth-1:0] one;
      logic signed [MaxAccWidth-1:0] rounded;
      logic signed [MaxAccWidth-1:0] hi;
      logic signed [MaxAccWidth-1:0] lo;
      one = {{(MaxAccWidth-1){1'b0}}, 1'b1};
      rounded = (shift > 0) ? ((value + (one <<< (shift - 1))) >>> shift) : value;
      hi = (one <<< (data_width - 1)) - one;
      lo = -(one <<< (data_width - 1));
      if (rounded > hi) return hi;
      if (rounded < lo) return lo;
      return rounded;
   endfunction

endpackage

// File: rtl/fir_mac.sv
// Signed multiply-accumulate unit shared by every tap and channel of the filter.
module fir_mac #(
   parameter int DataWidth  = 16,
   parameter int CoeffWidth = 16,
   parameter int AccWidth   = 39
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clear,
   input  logic                         en,
   input  logic signed [DataWidth-1:0]  sample,
   input  logic signed [CoeffWidth-1:0] coeff,
   output logic signed [AccWidth-1:0]   acc
);

   logic signed [DataWidth+CoeffWidth-1:0] product;

   assign product = sample * coeff;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + AccWidth'(product);
      end
   end

endmodule

// File: rtl/fir_filter_tdm.sv
// Multi-channel TDM FIR filter with one MAC, shared runtime coefficients and per-channel delay lines.
// Optional output rounding/saturation is enabled by defining FIR_ROUND_SAT_EN.
module fir_filter_tdm
   import fir_pkg::*;
#(
   parameter int Order       = 127,
   parameter int AddrWidth   = (Order < 1) ? 1 : $clog2(Order + 1),
   parameter int DataWidth   = 16,
   parameter int CoeffWidth  = 16,
   parameter int NumChannels = 1,
   parameter int ChWidth     = (NumChannels < 2) ? 1 : $clog2(NumChannels),
   parameter int AccWidth    = acc_width(DataWidth, CoeffWidth, Order),
   parameter int OutShift    = 15
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         coeff_we_i,
   output logic                         coeff_ready_o,
   input  logic [AddrWidth-1:0]         coeff_addr_i,
   input  logic signed [CoeffWidth-1:0] coeff_data_i,
   input  logic                         data_in_valid_i,
   output logic                         data_in_ready_o,
   input  logic signed [DataWidth-1:0]  data_in_i,
   input  logic [ChWidth-1:0]           data_in_ch_i,
   output logic                         data_out_valid_o,
   input  logic                         data_out_ready_i,
   output logic signed [AccWidth-1:0]   data_out_o,
   output logic [ChWidth-1:0]           data_out_ch_o
);

   localparam logic [AddrWidth-1:0] LastTap = AddrWidth'(Order);
   localparam logic [ChWidth-1:0]   LastCh  = ChWidth'(NumChannels - 1);
   localparam logic [ChWidth:0]     ChCount = (ChWidth + 1)'(NumChannels);

   if (Order < 0 || NumChannels < 1 || OutShift < 0 || OutShift >= AccWidth) begin : g_param_check
      $error("fir_filter_tdm: illegal parameter combination");
   end

   state_e state, next_state;

   logic [AddrWidth-1:0] tap, base, rd_idx;
   logic [ChWidth-1:0]   sweep_ch, cur_ch;
   logic [AddrWidth-1:0] ptr [2**ChWidth];

   logic signed [CoeffWidth-1:0] coeff_mem [2**AddrWidth];
   logic signed [DataWidth-1:0]  delay_mem [2**ChWidth][2**AddrWidth];

   logic accept, coeff_wr, mac_clear, mac_en, ch_valid, last_tap;
   logic signed [AccWidth-1:0] acc;

   assign ch_valid = {1'b0, data_in_ch_i} < ChCount;
   assign last_tap = tap == LastTap;

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= CLEAR;
      else       state <= next_state;
   end

   always_comb begin
      next_state       = state;
      data_in_ready_o  = 1'b0;
      coeff_ready_o    = 1'b0;
      data_out_valid_o = 1'b0;
      accept           = 1'b0;
      coeff_wr         = 1'b0;
      mac_clear        = 1'b0;
      mac_en           = 1'b0;
      case (state)
         CLEAR: if (last_tap && sweep_ch == LastCh) next_state = IDLE;
         IDLE: begin
            data_in_ready_o = 1'b1;
            coeff_ready_o   = 1'b1;
            coeff_wr        = coeff_we_i && (coeff_addr_i <= LastTap);
            // Samples for nonexistent channels are swallowed without leaving IDLE.
            if (data_in_valid_i && ch_valid) begin
               accept     = 1'b1;
               mac_clear  = 1'b1;
               next_state = MAC;
            end
         end
         MAC: begin
            mac_en = 1'b1;
            if (last_tap) next_state = OUT;
         end
         OUT: begin
            data_out_valid_o = 1'b1;
            if (data_out_ready_i) next_state = IDLE;
         end
         default: next_state = CLEAR;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tap      <= '0;
         sweep_ch <= '0;
         base     <= '0;
         rd_idx   <= '0;
         cur_ch   <= '0;
         for (int c = 0; c < 2**ChWidth; c++) ptr[c] <= '0;
      end else begin
         case (state)
            CLEAR: begin
               if (last_tap) begin
                  tap      <= '0;
                  sweep_ch <= (sweep_ch == LastCh) ? '0 : sweep_ch + 1'b1;
               end else begin
                  tap <= tap + 1'b1;
               end
            end
            IDLE: if (accept) begin
               tap    <= '0;
               base   <= ptr[data_in_ch_i];
               rd_idx <= ptr[data_in_ch_i];
               cur_ch <= data_in_ch_i;
            end
            MAC: begin
               // Walk the history backwards from the newest sample, wrapping at the tap count.
               rd_idx <= (rd_idx == '0) ? LastTap : rd_idx - 1'b1;
               if (last_tap) begin
                  tap         <= '0;
                  ptr[cur_ch] <= (base == LastTap) ? '0 : base + 1'b1;
               end else begin
                  tap <= tap + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         if (state == CLEAR) begin
            delay_mem[sweep_ch][tap] <= '0;
            coeff_mem[tap]           <= '0;
         end else begin
            if (coeff_wr) coeff_mem[coeff_addr_i] <= coeff_data_i;
            if (accept)   delay_mem[data_in_ch_i][ptr[data_in_ch_i]] <= data_in_i;
         end
      end
   end

   fir_mac #(
      .DataWidth (DataWidth),
      .CoeffWidth(CoeffWidth),
      .AccWidth  (AccWidth)
   ) u_mac (
      .clk   (clk_i),
      .rst   (rst_i),
      .clear (mac_clear),
      .en    (mac_en),
      .sample(delay_mem[cur_ch][rd_idx]),
      .coeff (coeff_mem[tap]),
      .acc   (acc)
   );

   assign data_out_ch_o = cur_ch;

`ifdef FIR_ROUND_SAT_EN
   logic signed [MaxAccWidth-1:0] rounded;
   assign rounded    = sat_round(MaxAccWidth'(acc), OutShift, DataWidth);
   assign data_out_o = rounded[AccWidth-1:0];
`else
   assign data_out_o = acc;
`endif

endmodule

// File: tb/tb_fir_filter_tdm.sv
// Directed bench for fir_filter_tdm: Order=3, three channels, hand-computed expected outputs.
module tb_fir_filter_tdm;

   localparam int Order       = 3;
   localparam int AddrWidth   = 3;
   localparam int DataWidth   = 16;
   localparam int CoeffWidth  = 16;
   localparam int NumChannels = 3;
   localparam int ChWidth     = 2;
   localparam int AccWidth    = 35;
   localparam int OutShift    = 15;

   logic clk = 1'b0;
   logic rst_i;
   logic coeff_we_i;
   logic coeff_ready_o;
   logic [AddrWidth-1:0] coeff_addr_i;
   logic signed [CoeffWidth-1:0] coeff_data_i;
   logic data_in_valid_i;
   logic data_in_ready_o;
   logic signed [DataWidth-1:0] data_in_i;
   logic [ChWidth-1:0] data_in_ch_i;
   logic data_out_valid_o;
   logic data_out_ready_i;
   logic signed [AccWidth-1:0] data_out_o;
   logic [ChWidth-1:0] data_out_ch_o;

   int total = 0;
   int bad = 0;
   int latency;
   int cycles;
   logic seen;

   longint imp_out [5] = '{1, 2, 3, 4, 0};
   logic signed [15:0] imp_in [5] = '{16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
   logic signed [15:0] ch1_in [4] = '{16'sd1, 16'sd0, 16'sd0, 16'sd0};
   longint ch1_out [4] = '{1, 2, 3, 4};
   longint ch2_out [4] = '{5, 15, 30, 50};
   logic signed [15:0] rs_in [4] = '{16'sh7FFF, 16'sh7FFF, -16'sd32768, -16'sd32768};
`ifdef FIR_ROUND_SAT_EN
   longint rs_out [4] = '{32766, 32767, -1, -32768};
`else
   longint rs_out [4] = '{1073676289, 2147352578, -32767, -2147418112};
`endif

   fir_filter_tdm #(
      .Order      (Order),
      .AddrWidth  (AddrWidth),
      .DataWidth  (DataWidth),
      .CoeffWidth (CoeffWidth),
      .NumChannels(NumChannels),
      .ChWidth    (ChWidth),
      .AccWidth   (AccWidth),
      .OutShift   (OutShift)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .coeff_we_i      (coeff_we_i),
      .coeff_ready_o   (coeff_ready_o),
      .coeff_addr_i    (coeff_addr_i),
      .coeff_data_i    (coeff_data_i),
      .data_in_valid_i (data_in_valid_i),
      .data_in_ready_o (data_in_ready_o),
      .data_in_i       (data_in_i),
      .data_in_ch_i    (data_in_ch_i),
      .data_out_valid_o(data_out_valid_o),
      .data_out_ready_i(data_out_ready_i),
      .data_out_o      (data_out_o),
      .data_out_ch_o   (data_out_ch_o)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // All tasks start and end on a falling edge.
   task automatic writeCoeff(input logic [AddrWidth-1:0] addr, input logic signed [CoeffWidth-1:0] value);
      int guard = 0;
      while (!coeff_ready_o && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("coeff_ready", longint'(coeff_ready_o), 1);
      coeff_we_i   = 1'b1;
      coeff_addr_i = addr;
      coeff_data_i = value;
      @(negedge clk);
      coeff_we_i = 1'b0;
   endtask

   task automatic applyStimulus(input logic [ChWidth-1:0] ch, input logic signed [DataWidth-1:0] x);
      int guard = 0;
      while (!data_in_ready_o && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("in_ready", longint'(data_in_ready_o), 1);
      data_in_valid_i = 1'b1;
      data_in_ch_i    = ch;
      data_in_i       = x;
      @(negedge clk);
      data_in_valid_i = 1'b0;
      latency = 1;
   endtask

   task automatic waitOutput(input string tag, input longint exp, input logic [ChWidth-1:0] exp_ch);
      while (!data_out_valid_o && latency < 40) begin
         @(negedge clk);
         latency++;
      end
      checkOutput({tag, "_valid"}, longint'(data_out_valid_o), 1);
      checkOutput({tag, "_latency"}, longint'(latency), Order + 2);
      checkOutput({tag, "_data"}, longint'(data_out_o), exp);
      checkOutput({tag, "_ch"}, longint'(data_out_ch_o), longint'(exp_ch));
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst_i = 1'b1;
      coeff_we_i = 1'b0;
      coeff_addr_i = '0;
      coeff_data_i = '0;
      data_in_valid_i = 1'b0;
      data_in_i = '0;
      data_in_ch_i = '0;
      data_out_ready_i = 1'b1;
      repeat (3) @(negedge clk);

      checkOutput("rst_in_ready", longint'(data_in_ready_o), 0);
      checkOutput("rst_coeff_ready", longint'(coeff_ready_o), 0);
      checkOutput("rst_valid", longint'(data_out_valid_o), 0);
      checkOutput("rst_data", longint'(data_out_o), 0);
      checkOutput("rst_ch", longint'(data_out_ch_o), 0);

      rst_i = 1'b0;
      cycles = 0;
      while (!data_in_ready_o && cycles < 100) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("clear_cycles", longint'(cycles), NumChannels * (Order + 1));

      writeCoeff(3'd0, 16'sd1);
      writeCoeff(3'd1, 16'sd2);
      writeCoeff(3'd2, 16'sd3);
      writeCoeff(3'd3, 16'sd4);

      $display("[TB] impulse response on channel 0");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(2'd0, imp_in[i]);
         waitOutput($sformatf("imp%0d", i), imp_out[i], 2'd0);
      end

      $display("[TB] interleaved channels 1 and 2");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(2'd1, ch1_in[i]);
         waitOutput($sformatf("ch1_%0d", i), ch1_out[i], 2'd1);
         applyStimulus(2'd2, 16'sd5);
         waitOutput($sformatf("ch2_%0d", i), ch2_out[i], 2'd2);
      end

      $display("[TB] out-of-range channel is discarded");
      applyStimulus(2'd3, 16'sd100);
      checkOutput("discard_idle", longint'(data_in_ready_o), 1);
      seen = 1'b0;
      repeat (10) begin
         if (data_out_valid_o) seen = 1'b1;
         @(negedge clk);
      end
      checkOutput("discard_no_output", longint'(seen), 0);
      applyStimulus(2'd2, 16'sd7);
      waitOutput("after_discard", 52, 2'd2);

      $display("[TB] output backpressure");
      data_out_ready_i = 1'b0;
      applyStimulus(2'd2, 16'sd0);
      waitOutput("bp", 49, 2'd2);
      for (int i = 0; i < 10; i++) begin
         checkOutput($sformatf("bp_hold_data%0d", i), longint'(data_out_o), 49);
         checkOutput($sformatf("bp_hold_valid%0d", i), longint'(data_out_valid_o), 1);
         checkOutput($sformatf("bp_in_ready%0d", i), longint'(data_in_ready_o), 0);
         checkOutput($sformatf("bp_coeff_ready%0d", i), longint'(coeff_ready_o), 0);
         @(negedge clk);
      end
      data_out_ready_i = 1'b1;
      @(negedge clk);
      checkOutput("bp_release_valid", longint'(data_out_valid_o), 0);
      checkOutput("bp_release_in_ready", longint'(data_in_ready_o), 1);

      $display("[TB] coefficient edge cases");
      writeCoeff(3'd5, 16'sd99);
      checkOutput("simul_in_ready", longint'(data_in_ready_o), 1);
      coeff_we_i      = 1'b1;
      coeff_addr_i    = 3'd0;
      coeff_data_i    = 16'sd10;
      data_in_valid_i = 1'b1;
      data_in_ch_i    = 2'd2;
      data_in_i       = 16'sd3;
      @(negedge clk);
      coeff_we_i      = 1'b0;
      data_in_valid_i = 1'b0;
      latency = 1;
      waitOutput("simul", 71, 2'd2);
      applyStimulus(2'd2, 16'sd1);
      waitOutput("after_simul", 44, 2'd2);

      $display("[TB] full-scale rounding and saturation");
      writeCoeff(3'd0, 16'sh7FFF);
      writeCoeff(3'd1, 16'sh7FFF);
      writeCoeff(3'd2, 16'sd0);
      writeCoeff(3'd3, 16'sd0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(2'd0, rs_in[i]);
         waitOutput($sformatf("rs%0d", i), rs_out[i], 2'd0);
      end

      $display("[TB] reset during MAC");
      applyStimulus(2'd2, 16'sd5);
      @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      checkOutput("midrst_valid", longint'(data_out_valid_o), 0);
      cycles = 0;
      seen = 1'b0;
      while (!data_in_ready_o && cycles < 100) begin
         @(negedge clk);
         cycles++;
         if (data_out_valid_o) seen = 1'b1;
      end
      checkOutput("midrst_clear_cycles", longint'(cycles), NumChannels * (Order + 1));
      checkOutput("midrst_no_output", longint'(seen), 0);
      applyStimulus(2'd2, 16'sd7);
      waitOutput("midrst_ch2", 0, 2'd2);
      applyStimulus(2'd0, 16'sd7);
      waitOutput("midrst_ch0", 0, 2'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
